setid_segmem_wb: RTL and testbench
==================================

Name: setid_segmem_wb

Overview:
- Segment-memory stage wrapped around Status_Engine_FSM.
- Holds the DEP x VTWID set-ID segment memory.
- Serves lookup reads that produce i_RAM_Data for the status engine, and accepts the engine's modified set IDs (o_SETID_MOD qualified by o_Done) as write-back requests.
- Write-backs are buffered in a small FIFO and drained into a single-port RAM. Reads always see the newest data, forwarded from the FIFO when a write is still pending.

Parameters:
- KWID, 104: key width.
- DWID, 8: data bits per segment.
- SEGWID, DWID+2: segment width including status bits.
- VTWID, SEGWID*(KWID/DWID) = 130: segment-memory word width.
- AWID, 8: address width.
- DEP, 1<<AWID: memory depth.
- FDEP, 4: write-back FIFO depth (power of two, minimum 2).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- i_Rd_En  in  1  lookup read request.
- i_Rd_Addr  in  AWID  lookup address.
- o_Rd_Ready  out  1  read accepted this cycle when high together with i_Rd_En.
- o_RAM_Data  out  VTWID  read data, goes to the status engine's i_RAM_Data.
- o_Rd_Valid  out  1  o_RAM_Data valid; one-cycle pulse.
- i_Wr_Valid  in  1  write-back request; driven by the status engine's o_Done.
- i_Wr_Addr  in  AWID  write-back address.
- i_Wr_Data  in  VTWID  write-back data; driven by the status engine's o_SETID_MOD.
- o_Wr_Ready  out  1  FIFO not full.
- o_Init_Done  out  1  memory clear complete.
- o_Overflow  out  1  sticky; set when i_Wr_Valid arrives while o_Wr_Ready is low.

Behaviour:
- Reset (rst=0 at a clock edge):
  - FIFO is emptied; pending writes are discarded.
  - FSM enters INIT and the clear address is set to 0.
  - Outputs: o_Rd_Ready=0, o_Rd_Valid=0, o_RAM_Data=0, o_Wr_Ready=0, o_Init_Done=0, o_Overflow=0.
  - A reset mid-operation behaves identically; INIT restarts from address 0.
- FSM states:
  - INIT: write 0 to RAM[clr_addr] each cycle. After address DEP-1 is written, go to RUN and set o_Init_Done=1. INIT lasts exactly DEP cycles. Reads and writes are not accepted in INIT.
  - RUN: normal operation; left only by reset.
- Write accept (RUN):
  - Push {addr, data} when i_Wr_Valid=1 and o_Wr_Ready=1.
  - o_Wr_Ready=1 iff FIFO count < FDEP, evaluated before this cycle's push/pop.
  - i_Wr_Valid with o_Wr_Ready=0: request dropped, o_Overflow set; it clears only on reset.
- RAM port arbitration (single port, one operation per cycle):
  - FIFO full: drain has priority and o_Rd_Ready=0.
  - Otherwise: o_Rd_Ready=1. A read wins if i_Rd_En=1; the drain pops the FIFO head only in cycles with no accepted read.
  - Push and pop in the same cycle are allowed; count stays unchanged.
- Read latency: read accepted at cycle N -> o_Rd_Valid=1 and o_RAM_Data at N+1. o_RAM_Data holds its value when o_Rd_Valid=0.
- Forwarding:
  - At accept, compare i_Rd_Addr with every valid FIFO entry and with a write pushed in the same cycle.
  - The youngest match supplies the data, and a same-cycle push counts as youngest. Otherwise the data comes from the RAM.
  - A read never returns stale data for an address with a pending write.
- FIFO pointers are AWID-independent, log2(FDEP)+1 bits, wrap modulo 2*FDEP; full/empty are decided by comparing the MSB and the remaining bits.
- Drain writes RAM[head.addr] = head.data; the entry leaves the FIFO in the same cycle.
- Repeated writes to the same address are all kept in order; the last one is what ends up in the RAM.

Decomposition:
- Package setid_pkg:
  - KWID, DWID, SEGWID, VTWID, AWID, DEP constants.
  - State encoding INIT=1'b0, RUN=1'b1.
  - FIFO entry layout {addr[AWID-1:0], data[VTWID-1:0]}.
- Sub-module setid_wb_fifo: FDEP-entry FIFO exposing every entry and its valid bit for forwarding comparison.
- RAM inferred in the top module as a single-port synchronous memory.

Test Plan:
- Reset then idle: o_Init_Done rises exactly 256 cycles after rst is released. Afterwards a read of address 0x37 returns 130'h0 one cycle later with o_Rd_Valid=1.
- Write addr 0x05 data 130'h3_FFFF with no reads: the FIFO drains next cycle. A later read of 0x05 returns 130'h3_FFFF.
- Forwarding: hold i_Rd_En every cycle. Write 0x10=A, then 0x10=B while both are still pending. Read 0x10 returns B; after the FIFO fills and drains, a later read still returns B.
- Full FIFO: 4 writes with continuous reads -> o_Wr_Ready=0 and o_Rd_Ready=0 on the next cycle, the drain pops one entry, and o_Rd_Ready returns to 1. A 5th write while not ready sets o_Overflow, and its data is never readable.
- Same-cycle push and read to 0x22 with data C: the read returns C at N+1.
- Reset asserted with 3 entries pending: after re-INIT, a read of those addresses returns 0, and o_Overflow is 0.

Source files
------------

// File: rtl/setid_pkg.sv
// Shared widths, FSM encoding and write-back FIFO entry layout for the set-ID segment memory.
package setid_pkg;
    localparam int KWID   = 104;
    localparam int DWID   = 8;
    localparam int SEGWID = DWID + 2;
    localparam int VTWID  = SEGWID * (KWID / DWID);
    localparam int AWID   = 8;
    localparam int DEP    = 1 << AWID;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic [AWID-1:0]  addr;
        logic [VTWID-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/setid_wb_fifo.sv
// Write-back FIFO; zero-latency head, entries exposed oldest-first for read forwarding.
// Never pushes when full or pops when empty; the caller is expected to gate with full/empty.
module setid_wb_fifo
    import setid_pkg::*;
#(
    parameter int FDEP = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_entry_t             din,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output wb_entry_t [FDEP-1:0]  ent,
    output logic [FDEP-1:0]       vld
);
    localparam int IW = $clog2(FDEP);
    localparam int PW = IW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    wb_entry_t     mem [FDEP];
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign full    = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[IW-1:0]] <= din;
    end

    always_comb begin
        for (int i = 0; i < FDEP; i++) begin
            ent[i] = mem[rd_ptr[IW-1:0] + IW'(i)];
            vld[i] = (PW'(i) < count);
        end
    end
endmodule

// File: rtl/setid_segmem_wb.sv
// Set-ID segment memory: 1-cycle lookup reads with forwarding from a write-back FIFO drained into single-port RAM.
// A full FIFO deasserts both o_Wr_Ready and o_Rd_Ready so the drain can make progress.
module setid_segmem_wb
    import setid_pkg::*;
#(
    parameter int FDEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_Rd_En,
    input  logic [AWID-1:0]  i_Rd_Addr,
    output logic             o_Rd_Ready,
    output logic [VTWID-1:0] o_RAM_Data,
    output logic             o_Rd_Valid,
    input  logic             i_Wr_Valid,
    input  logic [AWID-1:0]  i_Wr_Addr,
    input  logic [VTWID-1:0] i_Wr_Data,
    output logic             o_Wr_Ready,
    output logic             o_Init_Done,
    output logic             o_Overflow
);
    logic [0:0]            state;
    logic [AWID-1:0]       clr_addr;
    logic                  run;

    logic                  fifo_full;
    logic                  fifo_empty;
    wb_entry_t [FDEP-1:0]  fifo_ent;
    logic [FDEP-1:0]       fifo_vld;
    wb_entry_t             push_ent;

    logic                  rd_acc;
    logic                  push;
    logic                  pop;

    logic                  ram_we;
    logic [AWID-1:0]       ram_addr;
    logic [VTWID-1:0]      ram_wdata;
    logic [VTWID-1:0]      mem [DEP];
    logic [VTWID-1:0]      ram_q;

    logic                  fwd_hit;
    logic [VTWID-1:0]      fwd_data;
    logic                  fwd_hit_q;
    logic [VTWID-1:0]      fwd_q;
    logic                  rd_valid_q;
    logic                  overflow_q;

    assign run         = (state == ST_RUN);
    assign o_Rd_Ready  = run && !fifo_full;
    assign o_Wr_Ready  = run && !fifo_full;
    assign o_Init_Done = run;
    assign o_Rd_Valid  = rd_valid_q;
    assign o_Overflow  = overflow_q;
    assign o_RAM_Data  = fwd_hit_q ? fwd_q : ram_q;

    assign rd_acc   = i_Rd_En && o_Rd_Ready;
    assign push     = i_Wr_Valid && o_Wr_Ready;
    assign pop      = run && !fifo_empty && !rd_acc;
    assign push_ent = '{addr: i_Wr_Addr, data: i_Wr_Data};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_INIT;
            clr_addr <= '0;
        end else if (state == ST_INIT) begin
            clr_addr <= clr_addr + AWID'(1);
            if (clr_addr == AWID'(DEP - 1)) state <= ST_RUN;
        end
    end

    setid_wb_fifo #(
        .FDEP (FDEP)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_ent),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .ent   (fifo_ent),
        .vld   (fifo_vld)
    );

    // One RAM operation per cycle: clear during INIT, otherwise an accepted read beats the drain.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = fifo_ent[0].addr;
        ram_wdata = fifo_ent[0].data;
        if (!run) begin
            ram_we    = 1'b1;
            ram_addr  = clr_addr;
            ram_wdata = '0;
        end else if (rd_acc) begin
            ram_addr  = i_Rd_Addr;
        end else if (pop) begin
            ram_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ram_q <= '0;
        end else if (rd_acc) begin
            ram_q <= mem[ram_addr];
        end
    end

    // Entries are scanned oldest-first so later matches override; a same-cycle push is youngest of all.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < FDEP; i++) begin
            if (fifo_vld[i] && (fifo_ent[i].addr == i_Rd_Addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_ent[i].data;
            end
        end
        if (push && (i_Wr_Addr == i_Rd_Addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = i_Wr_Data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fwd_hit_q  <= 1'b0;
            fwd_q      <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                fwd_hit_q <= fwd_hit;
                fwd_q     <= fwd_data;
            end
            if (i_Wr_Valid && !o_Wr_Ready) overflow_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_setid_segmem_wb.sv
// Directed, table-driven bench for setid_segmem_wb with hand-computed expectations.
`timescale 1ns/1ps
module tb_setid_segmem_wb;
    import setid_pkg::*;

    localparam int FDEP = 4;
    localparam logic [VTWID-1:0] ZERO = '0;
    localparam logic [VTWID-1:0] V5 = 130'h3_FFFF;
    localparam logic [VTWID-1:0] DA = 130'h2_A5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
    localparam logic [VTWID-1:0] DB = 130'h1_5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5A;
    localparam logic [VTWID-1:0] DC = 130'h3_01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [VTWID-1:0] DD = 130'h0_11111111_11111111_11111111_11111111;
    localparam logic [VTWID-1:0] DE = 130'h2_22222222_22222222_22222222_22222222;
    localparam logic [VTWID-1:0] DF = 130'h3_33333333_33333333_33333333_33333333;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             i_Rd_En = 1'b0;
    logic [AWID-1:0]  i_Rd_Addr = '0;
    logic             o_Rd_Ready;
    logic [VTWID-1:0] o_RAM_Data;
    logic             o_Rd_Valid;
    logic             i_Wr_Valid = 1'b0;
    logic [AWID-1:0]  i_Wr_Addr = '0;
    logic [VTWID-1:0] i_Wr_Data = '0;
    logic             o_Wr_Ready;
    logic             o_Init_Done;
    logic             o_Overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    setid_segmem_wb #(.FDEP(FDEP)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_Rd_En     (i_Rd_En),
        .i_Rd_Addr   (i_Rd_Addr),
        .o_Rd_Ready  (o_Rd_Ready),
        .o_RAM_Data  (o_RAM_Data),
        .o_Rd_Valid  (o_Rd_Valid),
        .i_Wr_Valid  (i_Wr_Valid),
        .i_Wr_Addr   (i_Wr_Addr),
        .i_Wr_Data   (i_Wr_Data),
        .o_Wr_Ready  (o_Wr_Ready),
        .o_Init_Done (o_Init_Done),
        .o_Overflow  (o_Overflow)
    );

    typedef struct packed {
        logic             re;
        logic [AWID-1:0]  ra;
        logic             we;
        logic [AWID-1:0]  wa;
        logic [VTWID-1:0] wd;
        logic             rrdy;
        logic             wrdy;
        logic             vld;
        logic [VTWID-1:0] dat;
        logic             ovf;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input int re, input int ra, input int we, input int wa,
                                input logic [VTWID-1:0] wd, input int rr, input int wr,
                                input int vl, input logic [VTWID-1:0] dt, input int ov);
        vec_t v;
        v.re   = 1'(re);
        v.ra   = AWID'(ra);
        v.we   = 1'(we);
        v.wa   = AWID'(wa);
        v.wd   = wd;
        v.rrdy = 1'(rr);
        v.wrdy = 1'(wr);
        v.vld  = 1'(vl);
        v.dat  = dt;
        v.ovf  = 1'(ov);
        return v;
    endfunction

    task automatic chk(input string name, input logic [VTWID-1:0] act, input logic [VTWID-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_rd_ready"},  VTWID'(o_Rd_Ready),  ZERO);
        chk({name, "_rd_valid"},  VTWID'(o_Rd_Valid),  ZERO);
        chk({name, "_ram_data"},  o_RAM_Data,          ZERO);
        chk({name, "_wr_ready"},  VTWID'(o_Wr_Ready),  ZERO);
        chk({name, "_init_done"}, VTWID'(o_Init_Done), ZERO);
        chk({name, "_overflow"},  VTWID'(o_Overflow),  ZERO);
    endtask

    // Counts rising edges after reset release until o_Init_Done; bounded so a stuck INIT still ends.
    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (o_Init_Done !== 1'b1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 100) begin
                chk({name, "_busy_rd_ready"}, VTWID'(o_Rd_Ready), ZERO);
                chk({name, "_busy_wr_ready"}, VTWID'(o_Wr_Ready), ZERO);
            end
        end
        chk({name, "_cycles"}, VTWID'(n), VTWID'(256));
        @(negedge clk);
    endtask

    task automatic rd(input string name, input int addr, input logic [VTWID-1:0] exp);
        i_Rd_En   = 1'b1;
        i_Rd_Addr = AWID'(addr);
        @(negedge clk);
        i_Rd_En   = 1'b0;
        chk({name, "_valid"}, VTWID'(o_Rd_Valid), VTWID'(1));
        chk({name, "_data"},  o_RAM_Data, exp);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;
        wait_init("init");

        vecs[0]  = mk(1, 'h37, 0, 0,    ZERO, 1, 1, 1, ZERO, 0);
        vecs[1]  = mk(0, 0,    1, 'h05, V5,   1, 1, 0, ZERO, 0);
        vecs[2]  = mk(0, 0,    0, 0,    ZERO, 1, 1, 0, ZERO, 0);
        vecs[3]  = mk(1, 'h05, 0, 0,    ZERO, 1, 1, 1, V5,   0);
        vecs[4]  = mk(1, 'h00, 1, 'h10, DA,   1, 1, 1, ZERO, 0);
        vecs[5]  = mk(1, 'h01, 1, 'h10, DB,   1, 1, 1, ZERO, 0);
        vecs[6]  = mk(1, 'h10, 0, 0,    ZERO, 1, 1, 1, DB,   0);
        vecs[7]  = mk(1, 'h11, 1, 'h20, DD,   1, 1, 1, ZERO, 0);
        vecs[8]  = mk(1, 'h12, 1, 'h21, DE,   1, 1, 1, ZERO, 0);
        vecs[9]  = mk(1, 'h10, 1, 'h30, DF,   0, 0, 0, ZERO, 1);
        vecs[10] = mk(1, 'h10, 0, 0,    ZERO, 1, 1, 1, DB,   1);
        vecs[11] = mk(0, 0,    0, 0,    ZERO, 1, 1, 0, DB,   1);
        vecs[12] = mk(0, 0,    0, 0,    ZERO, 1, 1, 0, DB,   1);
        vecs[13] = mk(0, 0,    0, 0,    ZERO, 1, 1, 0, DB,   1);
        vecs[14] = mk(1, 'h10, 0, 0,    ZERO, 1, 1, 1, DB,   1);
        vecs[15] = mk(1, 'h30, 0, 0,    ZERO, 1, 1, 1, ZERO, 1);
        vecs[16] = mk(1, 'h20, 0, 0,    ZERO, 1, 1, 1, DD,   1);
        vecs[17] = mk(1, 'h22, 1, 'h22, DC,   1, 1, 1, DC,   1);
        vecs[18] = mk(0, 0,    0, 0,    ZERO, 1, 1, 0, DC,   1);
        vecs[19] = mk(1, 'h22, 0, 0,    ZERO, 1, 1, 1, DC,   1);

        for (int i = 0; i < 20; i++) begin
            i_Rd_En    = vecs[i].re;
            i_Rd_Addr  = vecs[i].ra;
            i_Wr_Valid = vecs[i].we;
            i_Wr_Addr  = vecs[i].wa;
            i_Wr_Data  = vecs[i].wd;
            #1;
            chk($sformatf("v%0d_rd_ready", i), VTWID'(o_Rd_Ready), VTWID'(vecs[i].rrdy));
            chk($sformatf("v%0d_wr_ready", i), VTWID'(o_Wr_Ready), VTWID'(vecs[i].wrdy));
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_rd_valid", i), VTWID'(o_Rd_Valid), VTWID'(vecs[i].vld));
            chk($sformatf("v%0d_ram_data", i), o_RAM_Data, vecs[i].dat);
            chk($sformatf("v%0d_overflow", i), VTWID'(o_Overflow), VTWID'(vecs[i].ovf));
        end

        // Three writes kept pending by back-to-back reads, then reset mid-operation.
        i_Rd_En    = 1'b1;
        i_Rd_Addr  = 8'h00;
        i_Wr_Valid = 1'b1;
        i_Wr_Addr  = 8'h40;
        i_Wr_Data  = DA;
        @(negedge clk);
        i_Wr_Addr  = 8'h41;
        i_Wr_Data  = DB;
        @(negedge clk);
        i_Rd_Addr  = 8'h41;
        i_Wr_Addr  = 8'h42;
        i_Wr_Data  = DC;
        @(negedge clk);
        i_Wr_Valid = 1'b0;
        i_Rd_En    = 1'b0;
        chk("pending_fwd_data", o_RAM_Data, DB);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midreset");
        rst = 1'b1;
        wait_init("reinit");
        rd("after_reset_40", 'h40, ZERO);
        rd("after_reset_41", 'h41, ZERO);
        rd("after_reset_42", 'h42, ZERO);
        chk("after_reset_overflow", VTWID'(o_Overflow), ZERO);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
